// File: rtl/kalman_predict.sv
// Kalman predict stage: x_pred = F*x and P_pred = F*P*F^T + Q in Q20.12, computed
// with a single time-shared signed MAC, one term per clock, fixed 468-cycle latency.
module kalman_predict #(
    parameter int N    = 6,
    parameter int DW   = 32,
    parameter int FRAC = 12,
    parameter int AW   = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N*DW-1:0]   x_flat,
    input  logic [N*N*DW-1:0] P_flat,
    input  logic [N*N*DW-1:0] F_flat,
    input  logic [N*N*DW-1:0] Q_flat,
    output logic [N*DW-1:0]   x_pred_flat,
    output logic [N*N*DW-1:0] P_pred_flat,
    output logic              busy,
    output logic              done,
    output logic              sat_flag
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (N > 1) ? $clog2(N * N) : 1;

    localparam logic signed [AW-1:0] ACC_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]        EL_MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        EL_MIN  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRED_X,
        S_MUL_FP,
        S_MUL_FPFT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [CW-1:0]          r_i, r_j, r_k;
    logic signed [AW-1:0]   r_acc;
    logic                   r_sat;

    logic signed [DW-1:0]   r_x  [N];
    logic signed [DW-1:0]   r_f  [N*N];
    logic signed [DW-1:0]   r_p  [N*N];
    logic signed [DW-1:0]   r_q  [N*N];
    logic signed [DW-1:0]   r_t  [N*N];
    logic signed [DW-1:0]   r_xp [N];
    logic signed [DW-1:0]   r_pp [N*N];

    logic [N*DW-1:0]        r_x_pred;
    logic [N*N*DW-1:0]      r_p_pred;

    logic                   w_last_i, w_last_j, w_last_k, w_fin;
    logic signed [DW-1:0]   w_a, w_b, w_q;
    logic signed [2*DW-1:0] w_prod;
    logic signed [AW-1:0]   w_term, w_base, w_sum;
    logic [DW-1:0]          w_res;
    logic                   w_sat_hit;
    logic [N*DW-1:0]        w_xp_flat;
    logic [N*N*DW-1:0]      w_pp_flat;

    function automatic logic [IW-1:0] flat_idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return IW'(r) * IW'(N) + IW'(c);
    endfunction

    assign w_last_i = (r_i == CW'(N - 1));
    assign w_last_j = (r_j == CW'(N - 1));
    assign w_last_k = (r_k == CW'(N - 1));
    assign w_fin    = (r_state == S_MUL_FPFT) && w_last_i && w_last_j && w_last_k;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        case (r_state)
            S_IDLE:     if (start) w_next_state = S_PRED_X;
            S_PRED_X:   if (w_last_i && w_last_k) w_next_state = S_MUL_FP;
            S_MUL_FP:   if (w_last_i && w_last_j && w_last_k) w_next_state = S_MUL_FPFT;
            S_MUL_FPFT: if (w_fin) w_next_state = S_DONE;
            S_DONE:     w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // Operand routing; the final product reads F with swapped indices instead of forming F^T.
    always_comb begin
        w_a = '0;
        w_b = '0;
        case (r_state)
            S_PRED_X: begin
                w_a = r_f[flat_idx(r_i, r_k)];
                w_b = r_x[r_k];
            end
            S_MUL_FP: begin
                w_a = r_f[flat_idx(r_i, r_k)];
                w_b = r_p[flat_idx(r_k, r_j)];
            end
            S_MUL_FPFT: begin
                w_a = r_t[flat_idx(r_i, r_k)];
                w_b = r_f[flat_idx(r_j, r_k)];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_q    = r_q[flat_idx(r_i, r_j)];
        w_prod = (2*DW)'(w_a) * (2*DW)'(w_b);
        w_term = AW'(w_prod >>> FRAC);
        if (r_k == '0) w_base = (r_state == S_MUL_FPFT) ? AW'(w_q) : '0;
        else           w_base = r_acc;
        w_sum     = w_base + w_term;
        w_sat_hit = 1'b0;
        if (w_sum > ACC_MAX) begin
            w_res     = EL_MAX;
            w_sat_hit = 1'b1;
        end else if (w_sum < ACC_MIN) begin
            w_res     = EL_MIN;
            w_sat_hit = 1'b1;
        end else begin
            w_res = w_sum[DW-1:0];
        end
    end

    // The last P element finishes on the same edge the outputs load, so it bypasses its buffer.
    always_comb begin
        w_xp_flat = '0;
        w_pp_flat = '0;
        for (int e = 0; e < N; e++)     w_xp_flat[DW*e +: DW] = r_xp[e];
        for (int e = 0; e < N * N; e++) w_pp_flat[DW*e +: DW] = r_pp[e];
        w_pp_flat[DW*(N*N-1) +: DW] = w_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_sat    <= 1'b0;
            r_x_pred <= '0;
            r_p_pred <= '0;
            // NOTE: these buffers are plain flops rather than a RAM, so clearing them in reset is legal.
            for (int e = 0; e < N; e++) begin
                r_x[e]  <= '0;
                r_xp[e] <= '0;
            end
            for (int e = 0; e < N * N; e++) begin
                r_f[e]  <= '0;
                r_p[e]  <= '0;
                r_q[e]  <= '0;
                r_t[e]  <= '0;
                r_pp[e] <= '0;
            end
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_i   <= '0;
                r_j   <= '0;
                r_k   <= '0;
                r_sat <= 1'b0;
                for (int e = 0; e < N; e++) r_x[e] <= x_flat[DW*e +: DW];
                for (int e = 0; e < N * N; e++) begin
                    r_f[e] <= F_flat[DW*e +: DW];
                    r_p[e] <= P_flat[DW*e +: DW];
                    r_q[e] <= Q_flat[DW*e +: DW];
                end
            end
        end else if (r_state != S_DONE) begin
            r_acc <= w_sum;
            r_k   <= w_last_k ? '0 : r_k + 1'b1;
            if (w_last_k) begin
                // The state-vector pass has no column index, so j stays at zero there.
                if (r_state == S_PRED_X || w_last_j) begin
                    r_j <= '0;
                    r_i <= w_last_i ? '0 : r_i + 1'b1;
                end else begin
                    r_j <= r_j + 1'b1;
                end
                if (w_sat_hit) r_sat <= 1'b1;
                case (r_state)
                    S_PRED_X:   r_xp[r_i]               <= w_res;
                    S_MUL_FP:   r_t[flat_idx(r_i, r_j)]  <= w_res;
                    S_MUL_FPFT: r_pp[flat_idx(r_i, r_j)] <= w_res;
                    default: ;
                endcase
            end
            if (w_fin) begin
                r_x_pred <= w_xp_flat;
                r_p_pred <= w_pp_flat;
            end
        end
    end

    assign x_pred_flat = r_x_pred;
    assign P_pred_flat = r_p_pred;
    assign sat_flag    = r_sat;

endmodule

// File: tb/tb_kalman_predict.sv
// Self-checking bench for kalman_predict: a matrix-level reference model plus a
// per-cycle compare process, directed cases with literal results, and random runs.
module tb_kalman_predict;
    localparam int N   = 6;
    localparam int DW  = 32;
    localparam int LAT = 468;

    logic              clk = 1'b0;
    logic              rst, start;
    logic [N*DW-1:0]   x_flat;
    logic [N*N*DW-1:0] P_flat, F_flat, Q_flat;
    logic [N*DW-1:0]   x_pred_flat;
    logic [N*N*DW-1:0] P_pred_flat;
    logic              busy, done, sat_flag;

    kalman_predict dut (
        .clk(clk), .rst(rst), .start(start),
        .x_flat(x_flat), .P_flat(P_flat), .F_flat(F_flat), .Q_flat(Q_flat),
        .x_pred_flat(x_pred_flat), .P_pred_flat(P_pred_flat),
        .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_x(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int e = 0; e < N; e++)
                if (act[DW*e +: DW] !== exp[DW*e +: DW]) begin
                    $display("FAIL %s: element %0d got %0h expected %0h", name, e, act[DW*e +: DW], exp[DW*e +: DW]);
                    break;
                end
        end
    endtask

    task automatic check_p(input string name, input logic [N*N*DW-1:0] act, input logic [N*N*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int e = 0; e < N * N; e++)
                if (act[DW*e +: DW] !== exp[DW*e +: DW]) begin
                    $display("FAIL %s: element (%0d,%0d) got %0h expected %0h", name, e / N, e % N,
                             act[DW*e +: DW], exp[DW*e +: DW]);
                    break;
                end
        end
    endtask

    // ---------------- reference model: plain matrix arithmetic ----------------
    function automatic longint mul_q(input longint a, input longint b);
        return (a * b) >>> 12;
    endfunction

    function automatic bit ovf(input longint v);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    function automatic longint clip(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    task automatic model_run(input logic [N*DW-1:0] xf, input logic [N*N*DW-1:0] pf, ff, qf,
                             output logic [N*DW-1:0] xo, output logic [N*N*DW-1:0] po, output bit so);
        longint x [N];
        longint f [N][N];
        longint p [N][N];
        longint q [N][N];
        longint t [N][N];
        longint s;
        xo = '0;
        po = '0;
        so = 1'b0;
        for (int i = 0; i < N; i++) begin
            x[i] = longint'($signed(xf[DW*i +: DW]));
            for (int j = 0; j < N; j++) begin
                f[i][j] = longint'($signed(ff[DW*(i*N+j) +: DW]));
                p[i][j] = longint'($signed(pf[DW*(i*N+j) +: DW]));
                q[i][j] = longint'($signed(qf[DW*(i*N+j) +: DW]));
            end
        end
        for (int i = 0; i < N; i++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += mul_q(f[i][k], x[k]);
            so |= ovf(s);
            xo[DW*i +: DW] = 32'(clip(s));
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += mul_q(f[i][k], p[k][j]);
                so |= ovf(s);
                t[i][j] = clip(s);
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = q[i][j];
                for (int k = 0; k < N; k++) s += mul_q(t[i][k], f[j][k]);
                so |= ovf(s);
                po[DW*(i*N+j) +: DW] = 32'(clip(s));
            end
    endtask

    // Cycle-level view of a run: idle, running (counting edges since acceptance), done cycle.
    int                m_phase = 0;
    int                m_cnt   = 0;
    logic [N*DW-1:0]   m_out_x = '0, m_pend_x = '0;
    logic [N*N*DW-1:0] m_out_p = '0, m_pend_p = '0;
    bit                m_out_sat = 1'b0, m_pend_sat = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_phase   = 0;
            m_cnt     = 0;
            m_out_x   = '0;
            m_out_p   = '0;
            m_out_sat = 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    model_run(x_flat, P_flat, F_flat, Q_flat, m_pend_x, m_pend_p, m_pend_sat);
                    m_phase = 1;
                    m_cnt   = 0;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == LAT) begin
                        m_out_x   = m_pend_x;
                        m_out_p   = m_pend_p;
                        m_out_sat = m_pend_sat;
                        m_phase   = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", busy, m_phase != 0);
            check("done", done, m_phase == 2);
            check_x("x_pred_flat", x_pred_flat, m_out_x);
            check_p("P_pred_flat", P_pred_flat, m_out_p);
            if (m_phase == 2) check("sat_flag", sat_flag, m_out_sat);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] xe(input int i);
        return x_pred_flat[DW*i +: DW];
    endfunction

    function automatic logic [31:0] pe(input int r, input int c);
        return P_pred_flat[DW*(r*N+c) +: DW];
    endfunction

    task automatic set_diag(output logic [N*N*DW-1:0] m, input logic [31:0] d);
        m = '0;
        for (int i = 0; i < N; i++) m[DW*(i*N+i) +: DW] = d;
    endtask

    function automatic logic [31:0] rnd(input int mode);
        int mag;
        int v;
        mag = (mode == 0) ? 65536 : (mode == 1) ? 1048576 : 4194304;
        v   = int'($urandom_range(0, 2 * mag)) - mag;
        return v;
    endfunction

    task automatic randomize_inputs(input int mode);
        for (int i = 0; i < N; i++) x_flat[DW*i +: DW] = rnd(mode);
        for (int e = 0; e < N * N; e++) begin
            P_flat[DW*e +: DW] = rnd(mode);
            F_flat[DW*e +: DW] = rnd(mode);
            Q_flat[DW*e +: DW] = rnd(mode);
        end
    endtask

    task automatic load_t1();
        for (int i = 0; i < N; i++) x_flat[DW*i +: DW] = 32'((i + 1) * 4096);
        set_diag(F_flat, 32'h1000);
        set_diag(P_flat, 32'h2000);
        Q_flat = '0;
    endtask

    task automatic wait_done(input int budget, output int d);
        d = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                d = cyc;
                break;
            end
        end
        if (d < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles, expected one", budget);
        end
    endtask

    task automatic run_once(input string name);
        int c0;
        int d;
        @(posedge clk);
        #1 start = 1'b1;
        c0 = cyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(600, d);
        check({name, "_latency"}, 64'(d - c0), 64'(LAT));
    endtask

    initial begin
        int c0, d1, d2, ndone;
        rst    = 1'b1;
        start  = 1'b0;
        x_flat = '0;
        P_flat = '0;
        F_flat = '0;
        Q_flat = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_sat", sat_flag, 1'b0);
        check_x("reset_x_pred", x_pred_flat, '0);
        check_p("reset_P_pred", P_pred_flat, '0);
        mon_en = 1'b1;

        // 1: identity transition, no process noise
        load_t1();
        run_once("t1");
        for (int i = 0; i < N; i++) check("t1_x_pred", xe(i), 32'((i + 1) * 4096));
        check("t1_P00", pe(0, 0), 32'h2000);
        check("t1_P55", pe(5, 5), 32'h2000);
        check("t1_P23", pe(2, 3), 32'h0);
        check("t1_sat", sat_flag, 1'b0);

        // 2: identity plus diagonal process noise
        set_diag(F_flat, 32'h1000);
        set_diag(P_flat, 32'h1000);
        set_diag(Q_flat, 32'h0800);
        x_flat = '0;
        run_once("t2");
        check("t2_P33", pe(3, 3), 32'h1800);
        check("t2_P55", pe(5, 5), 32'h1800);
        check("t2_P14", pe(1, 4), 32'h0);

        // 3: constant-velocity transition
        set_diag(F_flat, 32'h1000);
        F_flat[DW*1 +: DW] = 32'h1000;
        set_diag(P_flat, 32'h1000);
        Q_flat = '0;
        x_flat = '0;
        x_flat[0 +: DW]  = 32'h1000;
        x_flat[DW +: DW] = 32'h2000;
        run_once("t3");
        check("t3_x0", xe(0), 32'h3000);
        check("t3_x1", xe(1), 32'h2000);
        check("t3_P00", pe(0, 0), 32'h2000);
        check("t3_P01", pe(0, 1), 32'h1000);
        check("t3_P10", pe(1, 0), 32'h1000);
        check("t3_P11", pe(1, 1), 32'h1000);

        // 4a: floor rounding of a negative product
        set_diag(F_flat, 32'hFFFFF800);
        P_flat = '0;
        x_flat = '0;
        x_flat[0 +: DW] = 32'h1;
        run_once("t4a");
        check("t4a_x0", xe(0), 32'hFFFFFFFF);
        check("t4a_x1", xe(1), 32'h0);
        check("t4a_sat", sat_flag, 1'b0);

        // 4b: positive saturation
        set_diag(F_flat, 32'h003E8000);
        set_diag(P_flat, 32'h003E8000);
        run_once("t4b");
        check("t4b_P00", pe(0, 0), 32'h7FFFFFFF);
        check("t4b_P44", pe(4, 4), 32'h7FFFFFFF);
        check("t4b_P01", pe(0, 1), 32'h0);
        check("t4b_sat", sat_flag, 1'b1);

        // 5: reset at cycle 100 of a run aborts it
        load_t1();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (99) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_sat", sat_flag, 1'b0);
        check_x("t5_x_pred_zero", x_pred_flat, '0);
        check_p("t5_P_pred_zero", P_pred_flat, '0);
        ndone = 0;
        repeat (500) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("t5_no_done", 64'(ndone), 64'd0);
        run_once("t5_rerun");
        check("t5_P00", pe(0, 0), 32'h2000);

        // reset and start together: reset wins
        @(posedge clk);
        #1 begin rst = 1'b1; start = 1'b1; end
        @(posedge clk);
        #1 begin rst = 1'b0; start = 1'b0; end
        @(negedge clk);
        check("rst_start_busy", busy, 1'b0);

        // 6: start held high across two runs, inputs changed mid-run
        load_t1();
        @(posedge clk);
        #1 start = 1'b1;
        c0 = cyc + 1;
        repeat (50) @(posedge clk);
        #1 randomize_inputs(0);
        wait_done(600, d1);
        check("t6_first_latency", 64'(d1 - c0), 64'(LAT));
        check("t6_first_x0", xe(0), 32'h1000);
        check("t6_first_P11", pe(1, 1), 32'h2000);
        repeat (100) @(posedge clk);
        #1 randomize_inputs(1);
        wait_done(600, d2);
        check("t6_spacing", 64'(d2 - d1), 64'd470);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);

        // random runs across three magnitude ranges
        for (int r = 0; r < 6; r++) begin
            randomize_inputs(r % 3);
            run_once("rand");
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
